// File: rtl/audio_pll_lock_sequencer.sv
// Audio PLL start-up and recovery sequencer.
// Holds the PLL in reset, waits for a debounced lock, then releases the audio
// logic. Loss of lock re-runs the sequence. Failed attempts are counted, and
// running out of retries parks the block in a sticky FAULT state.
module audio_pll_lock_sequencer #(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               enable,
   input  logic                               pll_locked,
   output logic                               pll_rst,
   output logic                               audio_reset_n,
   output logic                               ready,
   output logic                               fault,
   output logic                               lost_lock,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
   output logic [2:0]                         state
);

   localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int CNT_MAX = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int RET_W   = $clog2(MAX_RETRIES+1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PLL_RESET = 3'd1,
      WAIT_LOCK = 3'd2,
      STABLE    = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } state_t;

   state_t             cur_state;
   state_t             nxt_state;
   logic [CNT_W-1:0]   cnt;
   logic [RET_W-1:0]   retry_nxt;
   logic               lock_meta;
   logic               lock_s;

   // Two-flop synchronizer for the asynchronous PLL lock indication
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Next-state and retry bookkeeping; lock beats a coincident timeout
   always_comb begin
      nxt_state = cur_state;
      retry_nxt = retry_count;
      if (!enable) begin
         nxt_state = IDLE;
         retry_nxt = '0;
      end else begin
         case (cur_state)
            IDLE: nxt_state = PLL_RESET;
            PLL_RESET: begin
               if (cnt == CNT_W'(RST_PULSE_CYCLES-1)) nxt_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  nxt_state = STABLE;
               end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES-1)) begin
                  if (retry_count != RET_W'(MAX_RETRIES)) retry_nxt = retry_count + RET_W'(1);
                  if (retry_nxt == RET_W'(MAX_RETRIES)) nxt_state = FAULT;
                  else                                  nxt_state = PLL_RESET;
               end
            end
            STABLE: begin
               if (!lock_s) begin
                  nxt_state = WAIT_LOCK;
               end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES-1)) begin
                  nxt_state = RUN;
                  retry_nxt = '0;
               end
            end
            RUN: begin
               retry_nxt = '0;
               if (!lock_s) nxt_state = PLL_RESET;
            end
            FAULT:   nxt_state = FAULT;
            default: nxt_state = IDLE;
         endcase
      end
   end

   // Shared cycle counter, restarted on every state change
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (nxt_state != cur_state) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Retry counter and the one-cycle lock-loss pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retry_count <= '0;
         lost_lock   <= 1'b0;
      end else begin
         retry_count <= retry_nxt;
         lost_lock   <= (cur_state == RUN) && (nxt_state == PLL_RESET);
      end
   end

   // Outputs decoded from the registered state
   always_comb begin
      pll_rst       = 1'b0;
      audio_reset_n = 1'b0;
      ready         = 1'b0;
      fault         = 1'b0;
      case (cur_state)
         IDLE, PLL_RESET: pll_rst = 1'b1;
         FAULT: begin
            pll_rst = 1'b1;
            fault   = 1'b1;
         end
         RUN: begin
            audio_reset_n = 1'b1;
            ready         = 1'b1;
         end
         default: ;
      endcase
   end

   assign state = cur_state;

endmodule
